mul_seq_unit: RTL and testbench

- Iterative multi-cycle multiplier that services the ALU's MUL/MULH/MULHSU/MULHU requests.
- It is the responder side of the ALU multiply handshake: it receives operands plus ALU_op and raises mul_stall until the product is ready.
- It keeps a one-entry product cache, so a MULH/MUL pair on the same operands costs only one computation.
- Sits beside the ALU adder/shifter; the ALU muxes res into its result when ALU_op is a multiply code.

---
 rtl/mul_seq_unit.sv | 173 +++++++++++++++++
 tb/tb_mul_seq_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_unit.sv
// mul_seq_unit: iterative shift-add multiplier answering the ALU's
// MUL/MULH/MULHSU/MULHU requests. A one-entry product cache lets a
// high/low pair on the same operands share one computation.
module mul_seq_unit #(
   parameter int         BITS_PER_CYCLE = 4,
   parameter logic [3:0] OP_MUL         = 4'd11,
   parameter logic [3:0] OP_MULH        = 4'd12,
   parameter logic [3:0] OP_MULHSU      = 4'd13,
   parameter logic [3:0] OP_MULHU       = 4'd14
) (
   input  logic        CLK,
   input  logic        nrst,
   input  logic        load_hazard,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic [3:0]  ALU_op,
   output logic [31:0] res,
   output logic        mul_stall
);

   localparam int N_ITER = 32 / BITS_PER_CYCLE;
   localparam int CW     = $clog2(N_ITER);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  count_q, count_d;
   logic [63:0]    acc_q, acc_d;
   logic [63:0]    mcand_q, mcand_d;    // |a|, shifted left each CALC cycle
   logic [31:0]    mplier_q, mplier_d;  // |b|, shifted right each CALC cycle
   logic           neg_q, neg_d;        // exactly one signed operand negative
   logic [31:0]    lat_a_q, lat_a_d;
   logic [31:0]    lat_b_q, lat_b_d;
   logic           lat_sa_q, lat_sa_d;
   logic           lat_sb_q, lat_sb_d;
   logic           cache_valid_q, cache_valid_d;
   logic [63:0]    cache_prod_q, cache_prod_d;
   logic [31:0]    key_a_q, key_a_d;
   logic [31:0]    key_b_q, key_b_d;
   logic           key_sa_q, key_sa_d;
   logic           key_sb_q, key_sb_d;

   logic           is_mul, req_sa, req_sb, hit, start;
   logic [31:0]    mag_a, mag_b;
   logic [63:0]    partial;

   // Request decode and cache lookup; MUL ignores signedness because the
   // low product half does not depend on it.
   always_comb begin
      is_mul = (ALU_op == OP_MUL) || (ALU_op == OP_MULH) ||
               (ALU_op == OP_MULHSU) || (ALU_op == OP_MULHU);
      req_sa = (ALU_op == OP_MULH) || (ALU_op == OP_MULHSU);
      req_sb = (ALU_op == OP_MULH);
      hit    = cache_valid_q && (op_a == key_a_q) && (op_b == key_b_q) &&
               ((ALU_op == OP_MUL) || ((req_sa == key_sa_q) && (req_sb == key_sb_q)));
      start  = (state_q == S_IDLE) && is_mul && !load_hazard && !hit;
      mag_a  = (req_sa && op_a[31]) ? (~op_a + 32'd1) : op_a;
      mag_b  = (req_sb && op_b[31]) ? (~op_b + 32'd1) : op_b;
   end

   // Sum of the BITS_PER_CYCLE partial products retired this CALC cycle.
   always_comb begin
      // NOTE: every variable assigned in always_comb gets a value before any
      // conditional path, otherwise synthesis infers a latch to hold it.
      partial = '0;
      for (int k = 0; k < BITS_PER_CYCLE; k++) begin
         if (mplier_q[k]) partial = partial + (mcand_q << k);
      end
   end

   // Next-state logic for the IDLE -> CALC -> FIN sequence and the cache.
   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      acc_d         = acc_q;
      mcand_d       = mcand_q;
      mplier_d      = mplier_q;
      neg_d         = neg_q;
      lat_a_d       = lat_a_q;
      lat_b_d       = lat_b_q;
      lat_sa_d      = lat_sa_q;
      lat_sb_d      = lat_sb_q;
      cache_valid_d = cache_valid_q;
      cache_prod_d  = cache_prod_q;
      key_a_d       = key_a_q;
      key_b_d       = key_b_q;
      key_sa_d      = key_sa_q;
      key_sb_d      = key_sb_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_CALC;
               count_d  = '0;
               acc_d    = '0;
               mcand_d  = {32'd0, mag_a};
               mplier_d = mag_b;
               neg_d    = (req_sa & op_a[31]) ^ (req_sb & op_b[31]);
               lat_a_d  = op_a;
               lat_b_d  = op_b;
               lat_sa_d = req_sa;
               lat_sb_d = req_sb;
            end
         end
         S_CALC: begin
            acc_d    = acc_q + partial;
            mcand_d  = mcand_q << BITS_PER_CYCLE;
            mplier_d = mplier_q >> BITS_PER_CYCLE;
            count_d  = count_q + CW'(1);
            if (count_q == CW'(N_ITER - 1)) state_d = S_FIN;
         end
         S_FIN: begin
            cache_prod_d  = neg_q ? (~acc_q + 64'd1) : acc_q;
            key_a_d       = lat_a_q;
            key_b_d       = lat_b_q;
            key_sa_d      = lat_sa_q;
            key_sb_d      = lat_sb_q;
            cache_valid_d = 1'b1;
            state_d       = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset clears the FSM, datapath and the cache entry.
   always_ff @(posedge CLK or negedge nrst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (!nrst) begin
         state_q       <= S_IDLE;
         count_q       <= '0;
         acc_q         <= '0;
         mcand_q       <= '0;
         mplier_q      <= '0;
         neg_q         <= 1'b0;
         lat_a_q       <= '0;
         lat_b_q       <= '0;
         lat_sa_q      <= 1'b0;
         lat_sb_q      <= 1'b0;
         cache_valid_q <= 1'b0;
         cache_prod_q  <= '0;
         key_a_q       <= '0;
         key_b_q       <= '0;
         key_sa_q      <= 1'b0;
         key_sb_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         acc_q         <= acc_d;
         mcand_q       <= mcand_d;
         mplier_q      <= mplier_d;
         neg_q         <= neg_d;
         lat_a_q       <= lat_a_d;
         lat_b_q       <= lat_b_d;
         lat_sa_q      <= lat_sa_d;
         lat_sb_q      <= lat_sb_d;
         cache_valid_q <= cache_valid_d;
         cache_prod_q  <= cache_prod_d;
         key_a_q       <= key_a_d;
         key_b_q       <= key_b_d;
         key_sa_q      <= key_sa_d;
         key_sb_q      <= key_sb_d;
      end
   end

   // Outputs: result straight from the cache on a hit; stall while a miss
   // is pending or a computation is in flight, and never during reset.
   always_comb begin
      res = '0;
      if (is_mul && hit) res = (ALU_op == OP_MUL) ? cache_prod_q[31:0] : cache_prod_q[63:32];
      mul_stall = nrst && (start || (state_q != S_IDLE));
   end

endmodule

// File: tb/tb_mul_seq_unit.sv
// tb_mul_seq_unit: directed and random requests against a reference model
// built from plain 64-bit arithmetic and a one-entry key cache.
module tb_mul_seq_unit;

   localparam logic [3:0] OP_MUL    = 4'd11;
   localparam logic [3:0] OP_MULH   = 4'd12;
   localparam logic [3:0] OP_MULHSU = 4'd13;
   localparam logic [3:0] OP_MULHU  = 4'd14;
   localparam int         MISS_LAT  = 32 / 4 + 2;

   logic        CLK = 1'b0;
   logic        nrst;
   logic        load_hazard;
   logic [31:0] op_a, op_b;
   logic [3:0]  ALU_op;
   logic [31:0] res;
   logic        mul_stall;

   int n_vec  = 0;
   int n_fail = 0;

   // Reference cache key.
   logic        m_valid;
   logic [31:0] m_a, m_b;
   logic        m_sa, m_sb;

   mul_seq_unit #(.BITS_PER_CYCLE(4)) dut (
      .CLK        (CLK),
      .nrst       (nrst),
      .load_hazard(load_hazard),
      .op_a       (op_a),
      .op_b       (op_b),
      .ALU_op     (ALU_op),
      .res        (res),
      .mul_stall  (mul_stall)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic op_sa(input logic [3:0] op);
      return (op == OP_MULH) || (op == OP_MULHSU);
   endfunction

   function automatic logic op_sb(input logic [3:0] op);
      return (op == OP_MULH);
   endfunction

   // Selected product half computed directly with 64-bit arithmetic.
   function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic signed [63:0] ax, bx;
      logic [63:0]        p;
      ax = op_sa(op) ? {{32{a[31]}}, a} : {32'd0, a};
      bx = op_sb(op) ? {{32{b[31]}}, b} : {32'd0, b};
      p  = ax * bx;
      return (op == OP_MUL) ? p[31:0] : p[63:32];
   endfunction

   function automatic logic ref_hit(input logic [3:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
      return m_valid && (a == m_a) && (b == m_b) &&
             ((op == OP_MUL) || ((op_sa(op) == m_sa) && (op_sb(op) == m_sb)));
   endfunction

   task automatic ref_fill(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      m_valid = 1'b1;
      m_a     = a;
      m_b     = b;
      m_sa    = op_sa(op);
      m_sb    = op_sb(op);
   endtask

   // Count stall cycles from now until mul_stall drops (bounded).
   task automatic count_stall(inout int cyc);
      while (mul_stall === 1'b1 && cyc < 64) begin
         cyc++;
         @(negedge CLK);
         #1;
      end
   endtask

   // Apply one multiply request and hold it until the block answers.
   task automatic run_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
      logic hit;
      int   cyc;
      hit         = ref_hit(op, a, b);
      ALU_op      = op;
      op_a        = a;
      op_b        = b;
      load_hazard = 1'b0;
      #1;
      cyc = 0;
      count_stall(cyc);
      check({tag, "_latency"}, 64'(cyc), 64'(hit ? 0 : MISS_LAT));
      check({tag, "_res"}, {32'd0, res}, {32'd0, ref_res(op, a, b)});
      check({tag, "_stall_low"}, {63'd0, mul_stall}, 64'd0);
      if (!hit) ref_fill(op, a, b);
   endtask

   initial begin
      logic [31:0] ra, rb, pool [5];
      logic [3:0]  rop;
      int          cyc;
      pool = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
      m_valid = 1'b0;
      m_a = '0; m_b = '0; m_sa = 1'b0; m_sb = 1'b0;

      // Reset with a multiply request present.
      nrst = 1'b0; load_hazard = 1'b0; ALU_op = OP_MUL; op_a = 32'd3; op_b = 32'd5;
      repeat (3) @(negedge CLK);
      #1;
      check("reset_res", {32'd0, res}, 64'd0);
      check("reset_stall", {63'd0, mul_stall}, 64'd0);
      @(negedge CLK);
      ALU_op = 4'd1;
      nrst   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("idle_add_stall", {63'd0, mul_stall}, 64'd0);
         @(negedge CLK);
      end

      // MUL miss, then signedness miss, then MUL hit on the same operands.
      run_req(OP_MUL, 32'hFFFFFFFF, 32'd2, "mul_miss");
      check("mul_miss_const", {32'd0, res}, 64'hFFFFFFFE);
      run_req(OP_MULH, 32'hFFFFFFFF, 32'd2, "mulh_reuse");
      check("mulh_reuse_const", {32'd0, res}, 64'hFFFFFFFF);
      run_req(OP_MUL, 32'hFFFFFFFF, 32'd2, "mul_hit");
      check("mul_hit_const", {32'd0, res}, 64'hFFFFFFFE);

      // Signedness corners on 0x80000000 squared.
      run_req(OP_MULH, 32'h80000000, 32'h80000000, "sq_mulh");
      check("sq_mulh_const", {32'd0, res}, 64'h40000000);
      run_req(OP_MULHU, 32'h80000000, 32'h80000000, "sq_mulhu");
      check("sq_mulhu_const", {32'd0, res}, 64'h40000000);
      run_req(OP_MULHSU, 32'h80000000, 32'h80000000, "sq_mulhsu");
      check("sq_mulhsu_const", {32'd0, res}, 64'hC0000000);
      run_req(OP_MUL, 32'h80000000, 32'h80000000, "sq_mul");
      check("sq_mul_const", {32'd0, res}, 64'h0);

      // Load hazard holds the request off; dropping it starts the stall.
      load_hazard = 1'b1; ALU_op = OP_MULH; op_a = 32'hFFFFFFFF; op_b = 32'd2;
      #1;
      check("hazard_stall", {63'd0, mul_stall}, 64'd0);
      @(negedge CLK);
      #1;
      check("hazard_stay_idle", {63'd0, mul_stall}, 64'd0);
      run_req(OP_MULH, 32'hFFFFFFFF, 32'd2, "hazard_release");
      check("hazard_release_const", {32'd0, res}, 64'hFFFFFFFF);

      // Operand change mid-computation: old one completes, new one recomputes.
      ALU_op = OP_MUL; op_a = 32'h0000_1234; op_b = 32'h0000_5678;
      #1;
      cyc = 0;
      repeat (3) begin
         if (mul_stall === 1'b1) cyc++;
         @(negedge CLK);
         #1;
      end
      op_a = 32'hDEAD_BEEF; op_b = 32'h0000_0011;
      count_stall(cyc);
      check("chg_latency", 64'(cyc), 64'(2 * MISS_LAT));
      check("chg_res", {32'd0, res}, {32'd0, ref_res(OP_MUL, 32'hDEAD_BEEF, 32'h11)});
      ref_fill(OP_MUL, 32'hDEAD_BEEF, 32'h11);
      run_req(OP_MUL, 32'h0000_1234, 32'h0000_5678, "chg_back");

      // Reset during CALC aborts; the held request then restarts from scratch.
      ALU_op = OP_MULHSU; op_a = 32'h9ABC_DEF0; op_b = 32'h1234_5678;
      repeat (5) @(negedge CLK);
      nrst = 1'b0;
      #1;
      check("midreset_stall", {63'd0, mul_stall}, 64'd0);
      check("midreset_res", {32'd0, res}, 64'd0);
      m_valid = 1'b0;
      @(negedge CLK);
      nrst = 1'b1;
      run_req(OP_MULHSU, 32'h9ABC_DEF0, 32'h1234_5678, "midreset_restart");

      // Random mix: fresh or reused operands, occasional non-multiply ops.
      ra = 32'd7; rb = 32'd9;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(4, 0) == 0) begin
            ALU_op = 4'($urandom_range(10, 0));
            op_a = $urandom; op_b = $urandom; load_hazard = 1'b0;
            #1;
            check("rnd_nonmul_res", {32'd0, res}, 64'd0);
            check("rnd_nonmul_stall", {63'd0, mul_stall}, 64'd0);
            @(negedge CLK);
         end else begin
            rop = 4'($urandom_range(14, 11));
            if ($urandom_range(1, 0) == 0) begin
               ra = ($urandom_range(2, 0) == 0) ? pool[$urandom_range(4, 0)] : $urandom;
               rb = ($urandom_range(2, 0) == 0) ? pool[$urandom_range(4, 0)] : $urandom;
            end
            run_req(rop, ra, rb, "rnd");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
